// File: rtl/pcm_bclk_frame_gen_if.sv
// Bus between the PCM bit-clock/frame generator and its consumers.
// The generator (master) takes the enable and divide value and drives
// the bit clock, edge strobes and frame position. The consumer side
// (slave) supplies the controls and samples everything else.
interface pcm_bclk_frame_gen_if #(
  parameter int DIV_WIDTH     = 8,
  parameter int BITS_PER_SLOT = 16,
  parameter int SLOTS         = 2
);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int BIT_W  = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;

  logic                 en_clk;
  logic [DIV_WIDTH-1:0] div;
  logic                 bclk;
  logic                 bclk_rise;
  logic                 bclk_fall;
  logic                 ws;
  logic                 frame_start;
  logic [SLOT_W-1:0]    slot;
  logic [BIT_W-1:0]     bit_idx;

  modport master (
    input  en_clk, div,
    output bclk, bclk_rise, bclk_fall, ws, frame_start, slot, bit_idx
  );

  modport slave (
    output en_clk, div,
    input  bclk, bclk_rise, bclk_fall, ws, frame_start, slot, bit_idx
  );
endinterface

// File: rtl/pcm_bclk_frame_gen.sv
// PCM bit-clock and frame generator. Divides clk into a programmable
// BCLK, emits one-cycle rise/fall strobes for downstream serialisers,
// tracks bit/slot position and drives WS in level (I2S) or pulse (TDM)
// form. All outputs are registered; en_clk low freezes everything.
module pcm_bclk_frame_gen #(
  parameter int DIV_WIDTH     = 8,
  parameter int BITS_PER_SLOT = 16,
  parameter int SLOTS         = 2,
  parameter int WS_MODE       = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pcm_bclk_frame_gen_if.master bus
);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int BIT_W  = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;

  // Reset parks position on the last bit of the frame so the first
  // falling edge lands on slot 0 bit 0.
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_SLOT - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SLOTS / 2);
  localparam logic WS_RESET = (WS_MODE == 1) ? ((SLOTS == 1) && (BITS_PER_SLOT == 1))
                                             : (SLOTS >= 2);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 bclk_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 fs_q;
  logic                 ws_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [BIT_W-1:0]     bit_q;
  logic [SLOT_W-1:0]    slot_nxt;
  logic [BIT_W-1:0]     bit_nxt;

  // Word-select value for a given frame position.
  function automatic logic ws_of(input logic [SLOT_W-1:0] s, input logic [BIT_W-1:0] b);
    if (WS_MODE == 1) return (s == '0) && (b == '0);
    else if (SLOTS < 2) return 1'b0;
    else return (s >= SLOT_HALF);
  endfunction

  // Position the next falling BCLK edge will move to.
  always_comb begin
    bit_nxt  = bit_q + 1'b1;
    slot_nxt = slot_q;
    if (bit_q == BIT_LAST) begin
      bit_nxt  = '0;
      slot_nxt = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
  end

  // Half-period counter, BCLK toggle, strobes and frame position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      bclk_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fs_q   <= 1'b0;
      ws_q   <= WS_RESET;
      slot_q <= SLOT_LAST;
      bit_q  <= BIT_LAST;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fs_q   <= 1'b0;
      if (bus.en_clk) begin
        // Live >= compare: lowering div ends the half-period at once,
        // raising it stretches the current one.
        if (cnt >= bus.div) begin
          cnt    <= '0;
          bclk_q <= ~bclk_q;
          rise_q <= ~bclk_q;
          fall_q <= bclk_q;
          if (bclk_q) begin
            bit_q  <= bit_nxt;
            slot_q <= slot_nxt;
            ws_q   <= ws_of(slot_nxt, bit_nxt);
            fs_q   <= (slot_nxt == '0) && (bit_nxt == '0);
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.bclk        = bclk_q;
  assign bus.bclk_rise   = rise_q;
  assign bus.bclk_fall   = fall_q;
  assign bus.frame_start = fs_q;
  assign bus.ws          = ws_q;
  assign bus.slot        = slot_q;
  assign bus.bit_idx     = bit_q;
endmodule
